// File: rtl/parity_frame_arbiter.sv
// Round-robin arbiter sharing a 2-bit/cycle XOR parity engine between NUM_REQ requesters.
// Optional PAR_CHECK_EN adds exp_parity input and err output comparing against an expected parity.
module parity_frame_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
`ifdef PAR_CHECK_EN
    input  logic [NUM_REQ-1:0]        exp_parity,
    output logic                      err,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      done,
    output logic                      parity,
    output logic [IDW-1:0]            done_id
);

    localparam int HALF = DATA_W / 2;
    localparam int CW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  sh;
    logic               acc;
    logic               acc_nx;
    logic [CW-1:0]      cnt;
    logic [IDW-1:0]     last;
    logic [IDW-1:0]     win;
    logic               any;
    logic [IDW:0]       cand;

    // Search last+1, last+2, ... with wraparound; one extra bit avoids overflow before the modulo.
    always_comb begin
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (!any && req[cand[IDW-1:0]]) begin
                any = 1'b1;
                win = cand[IDW-1:0];
            end
        end
    end

    assign acc_nx = acc ^ sh[0] ^ sh[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any) state_d = S_SHIFT;
            S_SHIFT: if (cnt == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sh      <= '0;
            acc     <= 1'b0;
            cnt     <= '0;
            gnt     <= '0;
            last    <= IDW'(NUM_REQ - 1);
            busy    <= 1'b0;
            done    <= 1'b0;
            parity  <= 1'b0;
            done_id <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (any) begin
                    sh   <= data[win*DATA_W +: DATA_W];
                    acc  <= 1'b0;
                    cnt  <= CW'(HALF);
                    gnt  <= NUM_REQ'(1) << win;
                    last <= win;
                    busy <= 1'b1;
                end
                S_SHIFT: begin
                    acc <= acc_nx;
                    sh  <= sh >> 2;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        parity  <= acc_nx;
                        done_id <= last;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    gnt  <= '0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PAR_CHECK_EN
    logic exp_q;

    // err is registered alongside done so it is only ever high in the DONE cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            exp_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (any) exp_q <= exp_parity[win];
                S_SHIFT: if (cnt == CW'(1)) err <= acc_nx ^ exp_q;
                S_DONE:  err <= 1'b0;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Bench for parity_frame_arbiter: vector table, corner sequences and a random run against a frame-level model.
module tb_parity_frame_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int H   = DW / 2;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  data = '0;
    logic [NR-1:0]     exp_parity = '0;
    logic [NR-1:0]     gnt;
    logic              busy, done, parity;
    logic [1:0]        done_id;
`ifdef PAR_CHECK_EN
    logic              err;
`endif

    int n_vec = 0;
    int n_mis = 0;

    parity_frame_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk(clk), .reset_b(reset_b), .req(req), .data(data),
`ifdef PAR_CHECK_EN
        .exp_parity(exp_parity), .err(err),
`endif
        .gnt(gnt), .busy(busy), .done(done), .parity(parity), .done_id(done_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, ".gnt"}, 32'(gnt), 0);
        check({nm, ".busy"}, 32'(busy), 0);
        check({nm, ".done"}, 32'(done), 0);
        check({nm, ".parity"}, 32'(parity), 0);
        check({nm, ".done_id"}, 32'(done_id), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        reset_b = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    typedef struct {
        int         idx;
        logic [7:0] word;
        logic       exp_par;
        bit         perturb;
    } vec_t;

    // Single-requester frame: grant next edge, done after H shift edges, then back to idle.
    task automatic run_frame(input vec_t v);
        int  n = 0;
        bit  seen = 0;
        @(negedge clk);
        req = '0;
        req[v.idx] = 1'b1;
        data[v.idx*DW +: DW] = v.word;
        @(posedge clk); #1;
        check("frame.gnt", 32'(gnt), 32'(1) << v.idx);
        check("frame.busy", 32'(busy), 1);
        @(negedge clk);
        req = '0;
        if (v.perturb) data = ~data;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = done;
        end
        check("frame.latency", 32'(n), H);
        check("frame.parity", 32'(parity), 32'(v.exp_par));
        check("frame.done_id", 32'(done_id), 32'(v.idx));
        check("frame.gnt_in_done", 32'(gnt), 32'(1) << v.idx);
        @(posedge clk); #1;
        check("frame.done_off", 32'(done), 0);
        check("frame.gnt_off", 32'(gnt), 0);
        check("frame.busy_off", 32'(busy), 0);
    endtask

`ifdef PAR_CHECK_EN
    task automatic par_frame(input logic e, input logic exp_err);
        int n = 0;
        bit seen = 0;
        @(negedge clk);
        req = 4'b0001;
        data[0 +: DW] = 8'h03;
        exp_parity = {3'b000, e};
        @(posedge clk); #1;
        @(negedge clk);
        req = '0;
        exp_parity = ~exp_parity;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = done;
            if (!seen) check("err.pre", 32'(err), 0);
        end
        check("err.done", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        check("err.post", 32'(err), 0);
    endtask
`endif

    // Frame-level reference: phase 0 is idle, 1..H counts shift edges, H+1 is the done cycle.
    int         m_ph;
    int         m_last;
    int         m_win;
    logic [7:0] m_word;
    logic       m_exp;
    logic [NR-1:0] m_gnt;
    logic       m_done, m_par, m_err;
    int         m_id;

    task automatic model_reset();
        m_ph = 0; m_last = NR - 1; m_win = 0; m_word = '0; m_exp = 0;
        m_gnt = '0; m_done = 0; m_par = 0; m_err = 0; m_id = 0;
    endtask

    task automatic model_step();
        if (m_ph == 0) begin
            if (req != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (req[(m_last + k) % NR]) begin
                        m_win = (m_last + k) % NR;
                        break;
                    end
                end
                m_last = m_win;
                m_word = data[m_win*DW +: DW];
                m_exp  = exp_parity[m_win];
                m_gnt  = '0;
                m_gnt[m_win] = 1'b1;
                m_ph   = 1;
            end
        end else if (m_ph <= H) begin
            if (m_ph == H) begin
                m_done = 1;
                m_par  = ^m_word;
                m_id   = m_win;
                m_err  = (^m_word) ^ m_exp;
            end
            m_ph++;
        end else begin
            m_done = 0;
            m_err  = 0;
            m_gnt  = '0;
            m_ph   = 0;
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 8'hB4, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{0, 8'h80, 1'b1, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{2, 8'h01, 1'b1, 1'b1};
        vecs[6] = '{1, 8'h5A, 1'b0, 1'b1};
        vecs[7] = '{3, 8'h13, 1'b1, 1'b0};

        do_reset();
        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset asserted mid-SHIFT aborts the frame with no done.
        begin
            int dn = 0;
            @(negedge clk);
            req = 4'b0001;
            data[0 +: DW] = 8'hFF;
            @(posedge clk);
            @(posedge clk);
            @(posedge clk); #2;
            reset_b = 1'b0;
            #1;
            check_idle_outputs("midreset");
            @(negedge clk);
            req = '0;
            reset_b = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            check("midreset.no_done", 32'(dn), 0);
        end

        // All requesters held: grants rotate 0,1,2,3,0 with done every H+2 cycles.
        begin
            int ids[$];
            int cycs[$];
            do_reset();
            @(negedge clk);
            req = 4'hF;
            for (int c = 1; c <= 60 && ids.size() < 5; c++) begin
                @(posedge clk); #1;
                if (done) begin
                    ids.push_back(int'(done_id));
                    cycs.push_back(c);
                    check("rr.gnt", 32'(gnt), 32'(1) << (ids.size() - 1) % NR);
                end
            end
            check("rr.count", 32'(ids.size()), 5);
            for (int i = 0; i < ids.size(); i++) begin
                check("rr.id", 32'(ids[i]), 32'(i % NR));
                if (i > 0) check("rr.spacing", 32'(cycs[i] - cycs[i-1]), H + 2);
            end
            @(negedge clk);
            req = '0;
        end

`ifdef PAR_CHECK_EN
        do_reset();
        par_frame(1'b1, 1'b1);
        par_frame(1'b0, 1'b0);
`endif

        // Random run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
            data = {$urandom};
            exp_parity = NR'($urandom);
            @(posedge clk);
            model_step();
            #1;
            check("rnd.gnt", 32'(gnt), 32'(m_gnt));
            check("rnd.busy", 32'(busy), 32'(m_ph != 0));
            check("rnd.done", 32'(done), 32'(m_done));
            check("rnd.parity", 32'(parity), 32'(m_par));
            check("rnd.done_id", 32'(done_id), 32'(m_id));
`ifdef PAR_CHECK_EN
            check("rnd.err", 32'(err), 32'(m_err));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
